fnd_capture: RTL and testbench

//  Receive side of the multiplexed 7-segment (FND) display bus. Samples the active-low segment lines.

---
 rtl/fnd_capture.sv | 163 ++++++++++++++++
 tb/tb_fnd_capture.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/fnd_capture.sv
// fnd_capture: receive side of a multiplexed 7-segment display bus.
// Registers the active-low segment lines and the one-hot digit selects, decodes
// each selected pattern back to a numeral, debounces scan glitches with a
// per-digit stability counter and holds the committed value per digit.
// Optional build macro: FND_CAPTURE_HEX_EN adds A..F glyph decoding.
module fnd_capture #(
    parameter int DIGITS     = 4,
    parameter int STABLE_CNT = 3
) (
    input  logic                  i_Clk,
    input  logic                  i_Rst,
    input  logic [6:0]            i_FND,
    input  logic [DIGITS-1:0]     i_Com,
    input  logic                  i_ErrClr,
    output logic [4*DIGITS-1:0]   o_Num,
    output logic [DIGITS-1:0]     o_Valid,
    output logic [DIGITS-1:0]     o_Blank,
    output logic                  o_Err,
    output logic                  o_Update
);

    localparam logic [3:0] STABLE  = 4'(STABLE_CNT);
    localparam logic [6:0] PAT_OFF = 7'b1111111;

    localparam logic [1:0] K_NUM   = 2'd0;
    localparam logic [1:0] K_BLANK = 2'd1;
    localparam logic [1:0] K_INV   = 2'd2;

    // Pattern -> {kind, value}; value is 0 unless kind is a numeral.
    function automatic logic [5:0] decode(input logic [6:0] p);
        case (p)
            7'b1000000: decode = {K_NUM, 4'h0};
            7'b1111001: decode = {K_NUM, 4'h1};
            7'b0100100: decode = {K_NUM, 4'h2};
            7'b0110000: decode = {K_NUM, 4'h3};
            7'b0011001: decode = {K_NUM, 4'h4};
            7'b0010010: decode = {K_NUM, 4'h5};
            7'b0000010: decode = {K_NUM, 4'h6};
            7'b1111000: decode = {K_NUM, 4'h7};
            7'b0000000: decode = {K_NUM, 4'h8};
            7'b0010000: decode = {K_NUM, 4'h9};
`ifdef FND_CAPTURE_HEX_EN
            7'b0001000: decode = {K_NUM, 4'hA};
            7'b0000011: decode = {K_NUM, 4'hB};
            7'b1000110: decode = {K_NUM, 4'hC};
            7'b0100001: decode = {K_NUM, 4'hD};
            7'b0000110: decode = {K_NUM, 4'hE};
            7'b0001110: decode = {K_NUM, 4'hF};
`endif
            PAT_OFF:    decode = {K_BLANK, 4'h0};
            default:    decode = {K_INV, 4'h0};
        endcase
    endfunction

    logic [6:0]          fnd_q, fnd_d;
    logic [DIGITS-1:0]   com_q, com_d;
    logic [6:0]          cand_q [DIGITS];
    logic [6:0]          cand_d [DIGITS];
    logic [3:0]          cnt_q  [DIGITS];
    logic [3:0]          cnt_d  [DIGITS];
    logic [4*DIGITS-1:0] num_q, num_d;
    logic [DIGITS-1:0]   valid_q, valid_d;
    logic [DIGITS-1:0]   blank_q, blank_d;
    logic                err_q, err_d;
    logic                upd_q, upd_d;

    logic                sel_one;
    logic                sel_multi;
    logic [5:0]          dec;
    logic [3:0]          new_val;
    logic                new_vld;
    logic                new_blk;

    // Classify the registered select lines: single digit, multi-hot or idle.
    always_comb begin
        sel_one   = ($countones(com_q) == 1);
        sel_multi = ($countones(com_q) > 1);
        dec       = decode(fnd_q);
    end

    // Stability tracking, commit of debounced digits and sticky error.
    always_comb begin
        fnd_d   = i_FND;
        com_d   = i_Com;
        num_d   = num_q;
        valid_d = valid_q;
        blank_d = blank_q;
        err_d   = err_q;
        upd_d   = 1'b0;
        new_val = 4'h0;
        new_vld = 1'b0;
        new_blk = 1'b0;

        // A clear request loses to any error event in the same cycle.
        if (i_ErrClr) err_d = 1'b0;
        if (sel_multi) err_d = 1'b1;

        for (int k = 0; k < DIGITS; k++) begin
            cand_d[k] = cand_q[k];
            cnt_d[k]  = cnt_q[k];
            if (sel_one && com_q[k]) begin
                if (fnd_q != cand_q[k]) begin
                    cand_d[k] = fnd_q;
                    cnt_d[k]  = 4'd1;
                end else if (cnt_q[k] < STABLE) begin
                    cnt_d[k] = cnt_q[k] + 4'd1;
                end
                // Commit only on the sample that brings the count to the
                // threshold; a digit already settled on this code is left alone.
                if (cnt_d[k] == STABLE &&
                    !(fnd_q == cand_q[k] && cnt_q[k] == STABLE)) begin
                    new_val = (dec[5:4] == K_NUM) ? dec[3:0] : 4'h0;
                    new_vld = (dec[5:4] == K_NUM);
                    new_blk = (dec[5:4] == K_BLANK);
                    if (dec[5:4] == K_INV) err_d = 1'b1;
                    if (new_val != num_q[4*k +: 4] || new_vld != valid_q[k] ||
                        new_blk != blank_q[k]) begin
                        upd_d = 1'b1;
                    end
                    num_d[4*k +: 4] = new_val;
                    valid_d[k]      = new_vld;
                    blank_d[k]      = new_blk;
                end
            end
        end
    end

    // State register; reset discards every candidate and counter mid-scan.
    always_ff @(posedge i_Clk) begin
        if (i_Rst) begin
            fnd_q   <= '0;
            com_q   <= '0;
            num_q   <= '0;
            valid_q <= '0;
            blank_q <= '0;
            err_q   <= 1'b0;
            upd_q   <= 1'b0;
            for (int k = 0; k < DIGITS; k++) begin
                cand_q[k] <= PAT_OFF;
                cnt_q[k]  <= 4'd0;
            end
        end else begin
            fnd_q   <= fnd_d;
            com_q   <= com_d;
            num_q   <= num_d;
            valid_q <= valid_d;
            blank_q <= blank_d;
            err_q   <= err_d;
            upd_q   <= upd_d;
            for (int k = 0; k < DIGITS; k++) begin
                cand_q[k] <= cand_d[k];
                cnt_q[k]  <= cnt_d[k];
            end
        end
    end

    assign o_Num    = num_q;
    assign o_Valid  = valid_q;
    assign o_Blank  = blank_q;
    assign o_Err    = err_q;
    assign o_Update = upd_q;

endmodule

// File: tb/tb_fnd_capture.sv
// Directed testbench for fnd_capture (DIGITS=4, STABLE_CNT=3).
module tb_fnd_capture;

    localparam logic [6:0] P0 = 7'b1000000;
    localparam logic [6:0] P1 = 7'b1111001;
    localparam logic [6:0] P2 = 7'b0100100;
    localparam logic [6:0] P3 = 7'b0110000;
    localparam logic [6:0] P4 = 7'b0011001;
    localparam logic [6:0] P5 = 7'b0010010;
    localparam logic [6:0] P7 = 7'b1111000;
    localparam logic [6:0] BL = 7'b1111111;
    localparam logic [6:0] PA = 7'b0001000;

    logic        clk = 1'b0;
    logic        rst;
    logic [6:0]  fnd;
    logic [3:0]  com;
    logic        clr;
    logic [15:0] num;
    logic [3:0]  valid;
    logic [3:0]  blank;
    logic        err;
    logic        upd;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        string       name;
        logic        rst;
        logic [3:0]  com;
        logic [6:0]  fnd;
        logic        clr;
        logic [15:0] num;
        logic [3:0]  valid;
        logic [3:0]  blank;
        logic        err;
        logic        upd;
    } vec_t;

    vec_t tbl[$];

    fnd_capture #(.DIGITS(4), .STABLE_CNT(3)) dut (
        .i_Clk    (clk),
        .i_Rst    (rst),
        .i_FND    (fnd),
        .i_Com    (com),
        .i_ErrClr (clr),
        .o_Num    (num),
        .o_Valid  (valid),
        .o_Blank  (blank),
        .o_Err    (err),
        .o_Update (upd)
    );

    always #5 clk = ~clk;

    task automatic add(input string nm, input logic r, input logic [3:0] c,
                       input logic [6:0] f, input logic cl, input logic [15:0] n,
                       input logic [3:0] v, input logic [3:0] b, input logic e,
                       input logic u);
        vec_t t;
        t.name = nm; t.rst = r; t.com = c; t.fnd = f; t.clr = cl;
        t.num = n; t.valid = v; t.blank = b; t.err = e; t.upd = u;
        tbl.push_back(t);
    endtask

    // Apply one cycle of inputs, then compare outputs 1 time unit after the edge.
    task automatic step(input string nm, input logic r, input logic [3:0] c,
                        input logic [6:0] f, input logic cl, input logic [15:0] n,
                        input logic [3:0] v, input logic [3:0] b, input logic e,
                        input logic u);
        logic [28:0] act;
        logic [28:0] exp;
        rst = r; com = c; fnd = f; clr = cl;
        @(posedge clk);
        #1;
        act = {num, valid, blank, err, upd};
        exp = {n, v, b, e, u};
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got num=%h valid=%b blank=%b err=%b upd=%b, want num=%h valid=%b blank=%b err=%b upd=%b",
                     nm, num, valid, blank, err, upd, n, v, b, e, u);
        end
    endtask

    initial begin
        rst = 1'b1; com = '0; fnd = BL; clr = 1'b0;

        // reset
        add("rst0", 1, 4'b0000, BL, 0, 16'h0000, 4'b0000, 4'b0000, 0, 0);
        add("rst1", 1, 4'b0000, BL, 0, 16'h0000, 4'b0000, 4'b0000, 0, 0);
        // single digit held: commit after edge 4
        add("t1_0", 0, 4'b0001, P2, 0, 16'h0000, 4'b0000, 4'b0000, 0, 0);
        add("t1_1", 0, 4'b0001, P2, 0, 16'h0000, 4'b0000, 4'b0000, 0, 0);
        add("t1_2", 0, 4'b0001, P2, 0, 16'h0000, 4'b0000, 4'b0000, 0, 0);
        add("t1_3", 0, 4'b0001, P2, 0, 16'h0002, 4'b0001, 4'b0000, 0, 1);
        add("t1_4", 0, 4'b0001, P2, 0, 16'h0002, 4'b0001, 4'b0000, 0, 0);
        // round-robin scan 1,2,3,4
        add("t2_a0", 0, 4'b0001, P1, 0, 16'h0002, 4'b0001, 4'b0000, 0, 0);
        add("t2_a1", 0, 4'b0001, P1, 0, 16'h0002, 4'b0001, 4'b0000, 0, 0);
        add("t2_a2", 0, 4'b0001, P1, 0, 16'h0002, 4'b0001, 4'b0000, 0, 0);
        add("t2_a3", 0, 4'b0001, P1, 0, 16'h0001, 4'b0001, 4'b0000, 0, 1);
        add("t2_b0", 0, 4'b0010, P2, 0, 16'h0001, 4'b0001, 4'b0000, 0, 0);
        add("t2_b1", 0, 4'b0010, P2, 0, 16'h0001, 4'b0001, 4'b0000, 0, 0);
        add("t2_b2", 0, 4'b0010, P2, 0, 16'h0001, 4'b0001, 4'b0000, 0, 0);
        add("t2_b3", 0, 4'b0010, P2, 0, 16'h0021, 4'b0011, 4'b0000, 0, 1);
        add("t2_c0", 0, 4'b0100, P3, 0, 16'h0021, 4'b0011, 4'b0000, 0, 0);
        add("t2_c1", 0, 4'b0100, P3, 0, 16'h0021, 4'b0011, 4'b0000, 0, 0);
        add("t2_c2", 0, 4'b0100, P3, 0, 16'h0021, 4'b0011, 4'b0000, 0, 0);
        add("t2_c3", 0, 4'b0100, P3, 0, 16'h0321, 4'b0111, 4'b0000, 0, 1);
        add("t2_d0", 0, 4'b1000, P4, 0, 16'h0321, 4'b0111, 4'b0000, 0, 0);
        add("t2_d1", 0, 4'b1000, P4, 0, 16'h0321, 4'b0111, 4'b0000, 0, 0);
        add("t2_d2", 0, 4'b1000, P4, 0, 16'h0321, 4'b0111, 4'b0000, 0, 0);
        add("t2_d3", 0, 4'b1000, P4, 0, 16'h4321, 4'b1111, 4'b0000, 0, 1);
        add("t2_e0", 0, 4'b0000, P4, 0, 16'h4321, 4'b1111, 4'b0000, 0, 0);
        // glitch filtering on digit 1: 5,5,7,5,5,5
        add("t3_0", 0, 4'b0010, P5, 0, 16'h4321, 4'b1111, 4'b0000, 0, 0);
        add("t3_1", 0, 4'b0010, P5, 0, 16'h4321, 4'b1111, 4'b0000, 0, 0);
        add("t3_2", 0, 4'b0010, P7, 0, 16'h4321, 4'b1111, 4'b0000, 0, 0);
        add("t3_3", 0, 4'b0010, P5, 0, 16'h4321, 4'b1111, 4'b0000, 0, 0);
        add("t3_4", 0, 4'b0010, P5, 0, 16'h4321, 4'b1111, 4'b0000, 0, 0);
        add("t3_5", 0, 4'b0010, P5, 0, 16'h4321, 4'b1111, 4'b0000, 0, 0);
        add("t3_6", 0, 4'b0000, P5, 0, 16'h4351, 4'b1111, 4'b0000, 0, 1);
        add("t3_7", 0, 4'b0000, P5, 0, 16'h4351, 4'b1111, 4'b0000, 0, 0);
        // multi-hot select, clear, and set-vs-clear priority
        add("t4_0", 0, 4'b0011, P0, 0, 16'h4351, 4'b1111, 4'b0000, 0, 0);
        add("t4_1", 0, 4'b0000, P0, 0, 16'h4351, 4'b1111, 4'b0000, 1, 0);
        add("t4_2", 0, 4'b0000, P0, 1, 16'h4351, 4'b1111, 4'b0000, 0, 0);
        add("t4_3", 0, 4'b0011, P0, 0, 16'h4351, 4'b1111, 4'b0000, 0, 0);
        add("t4_4", 0, 4'b0000, P0, 1, 16'h4351, 4'b1111, 4'b0000, 1, 0);
        add("t4_5", 0, 4'b0000, P0, 1, 16'h4351, 4'b1111, 4'b0000, 0, 0);
        // blank on digit 2, then 'A' glyph on digit 3
        add("t5_0", 0, 4'b0100, BL, 0, 16'h4351, 4'b1111, 4'b0000, 0, 0);
        add("t5_1", 0, 4'b0100, BL, 0, 16'h4351, 4'b1111, 4'b0000, 0, 0);
        add("t5_2", 0, 4'b0100, BL, 0, 16'h4351, 4'b1111, 4'b0000, 0, 0);
        add("t5_3", 0, 4'b0100, BL, 0, 16'h4051, 4'b1011, 4'b0100, 0, 1);
        add("t5_4", 0, 4'b1000, PA, 0, 16'h4051, 4'b1011, 4'b0100, 0, 0);
        add("t5_5", 0, 4'b1000, PA, 0, 16'h4051, 4'b1011, 4'b0100, 0, 0);
        add("t5_6", 0, 4'b1000, PA, 0, 16'h4051, 4'b1011, 4'b0100, 0, 0);
`ifdef FND_CAPTURE_HEX_EN
        add("t5_7", 0, 4'b0000, PA, 0, 16'hA051, 4'b1011, 4'b0100, 0, 1);
        add("t5_8", 0, 4'b0000, PA, 0, 16'hA051, 4'b1011, 4'b0100, 0, 0);
`else
        add("t5_7", 0, 4'b0000, PA, 0, 16'h0051, 4'b0011, 4'b0100, 1, 1);
        add("t5_8", 0, 4'b0000, PA, 0, 16'h0051, 4'b0011, 4'b0100, 1, 0);
`endif

        foreach (tbl[i]) begin
            step(tbl[i].name, tbl[i].rst, tbl[i].com, tbl[i].fnd, tbl[i].clr,
                 tbl[i].num, tbl[i].valid, tbl[i].blank, tbl[i].err, tbl[i].upd);
        end

        // Reset after two matching samples; one more sample afterwards must not commit.
        step("t6_0", 0, 4'b0001, P7, 0, tbl[tbl.size()-1].num, tbl[tbl.size()-1].valid,
             4'b0100, tbl[tbl.size()-1].err, 0);
        step("t6_1", 0, 4'b0001, P7, 0, tbl[tbl.size()-1].num, tbl[tbl.size()-1].valid,
             4'b0100, tbl[tbl.size()-1].err, 0);
        step("t6_2", 0, 4'b0001, P7, 0, tbl[tbl.size()-1].num, tbl[tbl.size()-1].valid,
             4'b0100, tbl[tbl.size()-1].err, 0);
        step("t6_rst", 1, 4'b0001, P7, 0, 16'h0000, 4'b0000, 4'b0000, 0, 0);
        step("t6_4", 0, 4'b0001, P7, 0, 16'h0000, 4'b0000, 4'b0000, 0, 0);
        step("t6_5", 0, 4'b0000, P7, 0, 16'h0000, 4'b0000, 4'b0000, 0, 0);
        step("t6_6", 0, 4'b0000, P7, 0, 16'h0000, 4'b0000, 4'b0000, 0, 0);
        step("t6_7", 0, 4'b0000, P7, 0, 16'h0000, 4'b0000, 4'b0000, 0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
